// File: rtl/edge_column_feeder.sv
// edge_column_feeder
//   Turns a raster stream of 3-bit classified pixels into vertical 3-pixel
//   window columns (rows y-2, y-1, y) using two line buffers. Each row is
//   followed by two all-zero pad columns. When EDGE_FEEDER_FLUSH_EN is
//   defined, the last row is flushed through R1 by an extra pass of IMG_W
//   columns (R2 = 0) plus two pad columns before the frame ends.
//
// Parameters
//   IMG_W          pixels per row (4..4096)
//   IMG_H          rows per frame (3..4096)
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   in_valid/in_ready/in_pix    input pixel handshake, raster order
//   out_valid/out_ready         output column handshake
//   R0, R1, R2     window column, top (y-2) to bottom (y)
//   out_ctr_valid  R1 row index lies inside the image
//   frame_done     one-cycle pulse when the frame ends
// Configuration macro
//   EDGE_FEEDER_FLUSH_EN  enables the FLUSH state
module edge_column_feeder #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] R0,
  output logic [2:0] R1,
  output logic [2:0] R2,
  output logic       out_ctr_valid,
  output logic       frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
`ifdef EDGE_FEEDER_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
  // During the flush pass y sits one past the last image row.
  localparam logic [YW-1:0] Y_FLUSH = YW'(IMG_H);
`endif

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pad_q, pad_d;
  logic          ov_q, ov_d;
  logic [2:0]    r0_q, r0_d;
  logic [2:0]    r1_q, r1_d;
  logic [2:0]    r2_q, r2_d;
  logic          ctr_q, ctr_d;
  logic          fd_q, fd_d;

  logic [2:0] lb1_q [IMG_W];
  logic [2:0] lb2_q [IMG_W];
  logic [2:0] lb1_rd, lb2_rd;

  logic load_ok;
  logic beat;

  assign lb1_rd  = lb1_q[x_q];
  assign lb2_rd  = lb2_q[x_q];
  assign load_ok = !ov_q || out_ready;
  // Gated by rst so in_ready reads 0 while reset is held.
  assign in_ready = rst && (state_q == ST_RUN) && load_ok;
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pad_d   = pad_q;
    ov_d    = ov_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ctr_d   = ctr_q;
    fd_d    = 1'b0;

    // A consumed (or empty) slot drops out_valid unless a new column loads below.
    if (load_ok) ov_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (beat) begin
          ov_d  = 1'b1;
          r0_d  = (y_q < YW'(2)) ? '0 : lb2_rd;
          r1_d  = (y_q == '0) ? '0 : lb1_rd;
          r2_d  = in_pix;
          ctr_d = (y_q != '0);
          if (x_q == X_LAST) begin
            x_d     = '0;
            pad_d   = 1'b0;
            state_d = ST_PAD;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      ST_PAD: begin
        if (load_ok) begin
          ov_d  = 1'b1;
          r0_d  = '0;
          r1_d  = '0;
          r2_d  = '0;
          ctr_d = 1'b0;
          pad_d = 1'b1;
          if (pad_q) begin
            pad_d = 1'b0;
`ifdef EDGE_FEEDER_FLUSH_EN
            if (y_q == Y_FLUSH) begin
              fd_d    = 1'b1;
              x_d     = '0;
              y_d     = '0;
              state_d = ST_RUN;
            end else if (y_q == Y_LAST) begin
              y_d     = y_q + 1'b1;
              state_d = ST_FLUSH;
            end else begin
              y_d     = y_q + 1'b1;
              state_d = ST_RUN;
            end
`else
            if (y_q == Y_LAST) begin
              fd_d    = 1'b1;
              x_d     = '0;
              y_d     = '0;
              state_d = ST_RUN;
            end else begin
              y_d     = y_q + 1'b1;
              state_d = ST_RUN;
            end
`endif
          end
        end
      end

`ifdef EDGE_FEEDER_FLUSH_EN
      ST_FLUSH: begin
        if (load_ok) begin
          ov_d  = 1'b1;
          r0_d  = lb2_rd;
          r1_d  = lb1_rd;
          r2_d  = '0;
          ctr_d = 1'b1;
          if (x_q == X_LAST) begin
            x_d     = '0;
            pad_d   = 1'b0;
            state_d = ST_PAD;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_RUN;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      x_q     <= '0;
      y_q     <= '0;
      pad_q   <= 1'b0;
      ov_q    <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      ctr_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pad_q   <= pad_d;
      ov_q    <= ov_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ctr_q   <= ctr_d;
      fd_q    <= fd_d;
    end
  end

  // Line buffers are never cleared; stale rows are masked by the y checks above.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb2_q[x_q] <= lb1_rd;
      lb1_q[x_q] <= in_pix;
    end
  end

  assign out_valid     = ov_q;
  assign R0            = r0_q;
  assign R1            = r1_q;
  assign R2            = r2_q;
  assign out_ctr_valid = ctr_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_edge_column_feeder.sv
module tb_edge_column_feeder;

  localparam int W = 4;
  localparam int H = 3;
`ifdef EDGE_FEEDER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif
  localparam int COLS_PER_FRAME = H * (W + 2) + (FLUSH_ON ? (W + 2) : 0);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_pix = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] R0, R1, R2;
  logic       out_ctr_valid;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  logic [2:0] pix_mem [0:63];
  logic [9:0] col_q [$];   // {ctr, R0, R1, R2} of each consumed column
  logic [9:0] exp_q [$];
  int fd_cnt;
  int fd_pos;

  edge_column_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .R0(R0), .R1(R1), .R2(R2),
    .out_ctr_valid(out_ctr_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference column sequence for one frame starting at pix_mem[base].
  task automatic add_expected_frame(input int base);
    logic [2:0] a, b, c;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        a = (y >= 2) ? pix_mem[base + (y - 2) * W + x] : 3'd0;
        b = (y >= 1) ? pix_mem[base + (y - 1) * W + x] : 3'd0;
        c = pix_mem[base + y * W + x];
        exp_q.push_back({(y >= 1), a, b, c});
      end
      exp_q.push_back(10'd0);
      exp_q.push_back(10'd0);
    end
    if (FLUSH_ON) begin
      for (int x = 0; x < W; x++) begin
        a = pix_mem[base + (H - 2) * W + x];
        b = pix_mem[base + (H - 1) * W + x];
        exp_q.push_back({1'b1, a, b, 3'd0});
      end
      exp_q.push_back(10'd0);
      exp_q.push_back(10'd0);
    end
  endtask

  // Feeds npix pixels, collects consumed columns until want_frames pulses seen.
  task automatic run_stream(input int npix, input bit toggle, input int want_frames,
                            input int budget, output bit timeout, output int stall_err);
    int acc;
    bit held;
    bit rdy;
    bit done;
    logic [9:0] held_col;
    logic [9:0] cur;
    acc = 0; held = 1'b0; rdy = 1'b1; done = 1'b0; held_col = '0;
    col_q.delete();
    fd_cnt = 0; fd_pos = -1; stall_err = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      out_ready = toggle ? rdy : 1'b1;
      rdy = ~rdy;
      in_valid = (acc < npix);
      in_pix = (acc < npix) ? pix_mem[acc] : 3'd0;
      #1;
      cur = {out_ctr_valid, R0, R1, R2};
      if (held && (!out_valid || cur !== held_col)) stall_err++;
      if (frame_done) begin
        fd_cnt++;
        fd_pos = col_q.size() + 1;
      end
      if (out_valid && !out_ready) begin
        held = 1'b1;
        held_col = cur;
        if (in_ready !== 1'b0) stall_err++;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) col_q.push_back(cur);
      if (in_valid && in_ready) acc++;
      if (fd_cnt >= want_frames && col_q.size() >= fd_pos) begin
        done = 1'b1;
        break;
      end
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, in_ready, out_ctr_valid, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid, in_ready, out_ctr_valid, frame_done});
    end
    checks++;
    if ({R0, R1, R2} !== 9'd0) begin
      errors++;
      $display("FAIL reset_cols: got %h expected 000", {R0, R1, R2});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_frame(input bit toggle, input string name);
    bit to;
    int se;
    for (int i = 0; i < 12; i++) pix_mem[i] = 3'((i + 1) % 8);
    exp_q.delete();
    add_expected_frame(0);
    run_stream(12, toggle, 1, 400, to, se);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %b expected 0", name, to); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL %s_stall: got %0d violations expected 0", name, se); end
    checks++;
    if (col_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_ncols: got %0d expected %0d", name, col_q.size(), exp_q.size());
    end
    for (int i = 0; i < col_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_col[%0d]: got %h expected %h", name, i, col_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL %s_fd_count: got %0d expected 1", name, fd_cnt); end
    checks++;
    if (fd_pos !== COLS_PER_FRAME) begin
      errors++;
      $display("FAIL %s_fd_pos: got %0d expected %0d", name, fd_pos, COLS_PER_FRAME);
    end
  endtask

  task automatic test_async_reset();
    int acc;
    bit to;
    int se;
    acc = 0;
    for (int i = 0; i < 12; i++) pix_mem[i] = 3'((i + 1) % 8);
    for (int cyc = 0; cyc < 50 && acc < 6; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_pix = pix_mem[acc];
      #1;
      if (in_ready) acc++;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, R2} !== {1'b1, pix_mem[5]}) begin
      errors++;
      $display("FAIL areset_pre: got %b expected %b", {out_valid, R2}, {1'b1, pix_mem[5]});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_ctr_valid, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_flags: got %b expected 0000", {out_valid, in_ready, out_ctr_valid, frame_done});
    end
    checks++;
    if ({R0, R1, R2} !== 9'd0) begin
      errors++;
      $display("FAIL areset_cols: got %h expected 000", {R0, R1, R2});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) pix_mem[i] = 3'd4;
    exp_q.delete();
    add_expected_frame(0);
    run_stream(12, 1'b0, 1, 400, to, se);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL areset_timeout: got %b expected 0", to); end
    checks++;
    if (col_q.size() === 0 || col_q[0] !== {1'b0, 3'd0, 3'd0, 3'd4}) begin
      errors++;
      $display("FAIL areset_first_col: got %h expected %h", (col_q.size() > 0) ? col_q[0] : 10'h3ff, {1'b0, 3'd0, 3'd0, 3'd4});
    end
    checks++;
    if (col_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL areset_ncols: got %0d expected %0d", col_q.size(), exp_q.size());
    end
    for (int i = 0; i < col_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL areset_col[%0d]: got %h expected %h", i, col_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int se;
    for (int i = 0; i < 12; i++) pix_mem[i] = 3'((i + 1) % 8);
    for (int i = 12; i < 24; i++) pix_mem[i] = 3'((i * 3 + 5) % 8);
    exp_q.delete();
    add_expected_frame(0);
    add_expected_frame(12);
    run_stream(24, 1'b0, 2, 800, to, se);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got %b expected 0", to); end
    checks++;
    if (fd_cnt !== 2) begin errors++; $display("FAIL b2b_fd_count: got %0d expected 2", fd_cnt); end
    checks++;
    if (col_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_ncols: got %0d expected %0d", col_q.size(), exp_q.size());
    end
    for (int i = 0; i < col_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_col[%0d]: got %h expected %h", i, col_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, "frame");
    test_frame(1'b1, "stall");
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_column_feeder.md
EDGE_COLUMN_FEEDER -- requirements
Module: edge_column_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per row (4..4096).
REQ-002 SHALL have parameter IMG_H, default 480, rows per frame (3..4096).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_pix valid.
REQ-006 SHALL have port in_ready  output  1  feeder accepts in_pix this cycle.
REQ-007 SHALL have port in_pix  input  3  classified pixel, raster order (bit2 strong, bit1 weak, bit0 reserved).
REQ-008 SHALL have port out_valid  output  1  R0/R1/R2 hold a valid column.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the column.
REQ-010 SHALL have ports R0, R1, R2  output  3 each  window column, rows y-2, y-1, y (top to bottom).
REQ-011 SHALL have port out_ctr_valid  output  1  R1 row index is within 0..IMG_H-1.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 SHALL hold two line buffers LB1 (row y-1) and LB2 (row y-2), each IMG_W x 3 bits, indexed by column counter x.
REQ-014 SHALL implement states RUN, PAD, FLUSH; after reset the state is RUN with x=0, y=0.
REQ-015 SHALL assert in_ready only in RUN when (!out_valid || out_ready).
REQ-016 SHALL, on an input beat in RUN (in_valid && in_ready), register R0=LB2[x], R1=LB1[x], R2=in_pix, set out_valid, write LB2[x]<=LB1[x] and LB1[x]<=in_pix, and increment x; latency from beat to out_valid is one cycle.
REQ-017 SHALL force R0 to 0 when y<2 and R1 to 0 when y<1; buffer contents are never cleared.
REQ-018 SHALL hold R0/R1/R2/out_valid stable while out_valid && !out_ready; out_valid deasserts only after a consumed column with no new column to load.
REQ-019 SHALL, after the beat with x=IMG_W-1, reset x to 0 and enter PAD.
REQ-020 SHALL, in PAD, emit exactly 2 all-zero columns (one per load opportunity, no input accepted), then increment y and return to RUN; if the completed row was y=IMG_H-1, go to FLUSH (EDGE_FEEDER_FLUSH_EN) or end frame.
REQ-021 SHALL, in FLUSH, emit IMG_W columns R0=LB2[x], R1=LB1[x], R2=0 (no LB writes), then 2 zero pad columns, then end frame.
REQ-022 SHALL, at end of frame, pulse frame_done for one cycle, set x=0, y=0, state RUN.
REQ-023 SHALL drive out_ctr_valid=1 on non-pad columns when R1 row index (y-1) is within 0..IMG_H-1; 0 on pad columns and row y=0.
REQ-024 SHALL size x and y counters to $clog2 of IMG_W and IMG_H+1; no wrap other than REQ-019/REQ-022.

Reset
REQ-025 SHALL, on rst low, asynchronously clear out_valid, in_ready, R0, R1, R2, out_ctr_valid, frame_done to 0, x and y to 0, state to RUN.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the first post-reset beat is row 0 column 0.

Configuration
REQ-027 SHALL compile the FLUSH state only when macro EDGE_FEEDER_FLUSH_EN is defined; without it, row IMG_H-1 pad goes directly to end of frame and the last image row is never presented on R1.

Verification
REQ-028 IMG_W=4, IMG_H=3, FLUSH on, out_ready=1, in_valid=1, pixels 1..12 (mod 8): columns R2 = 1,2,3,4,0,0,5,6,... ; row 1 R1 = 1,2,3,4; frame_done pulses once after 4 flush + 2 pad columns.
REQ-029 Same frame, out_ready toggled 1/0 each cycle: column sequence identical to REQ-028, outputs stable while out_ready=0, in_ready=0 during stalls.
REQ-030 rst low asynchronously at row 1 col 2, then new frame of 4'h4 (strong) pixels: outputs 0 during reset; first post-reset column R0=R1=0, R2=4.
REQ-031 FLUSH off: same stimulus as REQ-028 -> frame_done after row-2 pad, no R2=0 flush columns, total 18 columns.
REQ-032 Back-to-back frames with in_valid held high: second frame row 0 shows R0=R1=0 despite stale buffers; out_ctr_valid=0 for all row-0 columns.
